// File: rtl/event_fragment_writer.sv
// Per-TURFIO event writer: writes one fixed-length fragment into an event buffer
// through a DataMover S2MM channel and returns a 64-bit completion.
module event_fragment_writer #(
  parameter int unsigned TIO_INDEX    = 0,
  parameter int unsigned FRAG_BYTES   = 114752,
  parameter logic [18:0] START_OFFSET = 19'h03E00
) (
  input  logic        memclk,
  input  logic        memresetn,
  input  logic [11:0] s_addr_tdata,
  input  logic        s_addr_tvalid,
  output logic        s_addr_tready,
  input  logic [63:0] s_data_tdata,
  input  logic        s_data_tlast,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  output logic [71:0] m_cmd_tdata,
  output logic        m_cmd_tvalid,
  input  logic        m_cmd_tready,
  input  logic [7:0]  m_sts_tdata,
  input  logic        m_sts_tvalid,
  output logic        m_sts_tready,
  output logic [63:0] m_wr_tdata,
  output logic [7:0]  m_wr_tkeep,
  output logic        m_wr_tlast,
  output logic        m_wr_tvalid,
  input  logic        m_wr_tready,
  output logic [63:0] m_cmpl_tdata,
  output logic        m_cmpl_tvalid,
  input  logic        m_cmpl_tready,
  output logic        frag_err_o
);

  localparam int unsigned BEATS     = FRAG_BYTES / 8;
  localparam logic [14:0] LAST_BEAT = 15'(BEATS - 1);
  localparam logic [18:0] LADDR     = 19'(32'(START_OFFSET) + TIO_INDEX * FRAG_BYTES);
  localparam logic [22:0] BTT       = 23'(FRAG_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_DATA, ST_PAD, ST_DRAIN, ST_STATUS, ST_CMPL
  } state_t;

  state_t      state_reg, state_next;
  logic [14:0] beat_reg, beat_next;
  logic [11:0] upper_reg, upper_next;
  logic [5:0]  err_reg, err_next;
  logic        frag_err_reg, frag_err_next;
  logic        final_beat;
  logic        unused_sts;

  // Status bits [3:0] carry the DataMover tag, which this block never issues.
  assign unused_sts = ^m_sts_tdata[3:0];
  assign final_beat = (beat_reg == LAST_BEAT);

  assign m_cmd_tdata  = {8'h00, 1'b0, upper_reg, LADDR, 1'b0, 1'b1, 6'b000000, 1'b1, BTT};
  assign m_cmpl_tdata = {20'h00000, upper_reg, 26'h0000000, err_reg};
  assign m_wr_tkeep   = 8'hFF;
  assign frag_err_o   = frag_err_reg;

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      state_reg    <= ST_IDLE;
      beat_reg     <= '0;
      upper_reg    <= '0;
      err_reg      <= '0;
      frag_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_reg     <= beat_next;
      upper_reg    <= upper_next;
      err_reg      <= err_next;
      frag_err_reg <= frag_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    upper_next    = upper_reg;
    err_next      = err_reg;
    frag_err_next = frag_err_reg;
    s_addr_tready = 1'b0;
    s_data_tready = 1'b0;
    m_cmd_tvalid  = 1'b0;
    m_sts_tready  = 1'b0;
    m_wr_tdata    = 64'h0;
    m_wr_tlast    = 1'b0;
    m_wr_tvalid   = 1'b0;
    m_cmpl_tvalid = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        s_addr_tready = 1'b1;
        if (s_addr_tvalid) begin
          upper_next = s_addr_tdata;
          err_next   = '0;
          state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        m_cmd_tvalid = 1'b1;
        if (m_cmd_tready) begin
          beat_next  = '0;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        m_wr_tvalid   = s_data_tvalid;
        s_data_tready = m_wr_tready;
        m_wr_tdata    = s_data_tdata;
        m_wr_tlast    = final_beat;
        if (s_data_tvalid && m_wr_tready) begin
          if (final_beat) begin
            if (!s_data_tlast) begin
              err_next[5] = 1'b1;
              state_next  = ST_DRAIN;
            end else begin
              state_next = ST_STATUS;
            end
          end else begin
            beat_next = beat_reg + 15'd1;
            if (s_data_tlast) begin
              err_next[4] = 1'b1;
              state_next  = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        // Zero-fill so the S2MM transfer still totals exactly FRAG_BYTES.
        m_wr_tvalid = 1'b1;
        m_wr_tlast  = final_beat;
        if (m_wr_tready) begin
          if (final_beat) state_next = ST_STATUS;
          else            beat_next  = beat_reg + 15'd1;
        end
      end
      ST_DRAIN: begin
        s_data_tready = 1'b1;
        if (s_data_tvalid && s_data_tlast) state_next = ST_STATUS;
      end
      ST_STATUS: begin
        m_sts_tready = 1'b1;
        if (m_sts_tvalid) begin
          err_next[0] = err_reg[0] | m_sts_tdata[6];
          err_next[1] = err_reg[1] | m_sts_tdata[5];
          err_next[2] = err_reg[2] | m_sts_tdata[4];
          err_next[3] = err_reg[3] | ~m_sts_tdata[7];
          state_next  = ST_CMPL;
        end
      end
      ST_CMPL: begin
        m_cmpl_tvalid = 1'b1;
        if (m_cmpl_tready) begin
          frag_err_next = frag_err_reg | (err_reg != 6'd0);
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_event_fragment_writer.sv
// Scoreboard bench for event_fragment_writer with an 8-beat fragment in TURFIO slot 2.
module tb_event_fragment_writer;

  logic        memclk = 1'b0;
  logic        memresetn = 1'b0;
  logic [11:0] s_addr_tdata;
  logic        s_addr_tvalid, s_addr_tready;
  logic [63:0] s_data_tdata;
  logic        s_data_tlast, s_data_tvalid, s_data_tready;
  logic [71:0] m_cmd_tdata;
  logic        m_cmd_tvalid, m_cmd_tready;
  logic [7:0]  m_sts_tdata;
  logic        m_sts_tvalid, m_sts_tready;
  logic [63:0] m_wr_tdata;
  logic [7:0]  m_wr_tkeep;
  logic        m_wr_tlast, m_wr_tvalid, m_wr_tready;
  logic [63:0] m_cmpl_tdata;
  logic        m_cmpl_tvalid, m_cmpl_tready;
  logic        frag_err_o;

  always #5 memclk = ~memclk;

  event_fragment_writer #(.TIO_INDEX(2), .FRAG_BYTES(64), .START_OFFSET(19'h03E00)) dut (
    .memclk(memclk), .memresetn(memresetn),
    .s_addr_tdata(s_addr_tdata), .s_addr_tvalid(s_addr_tvalid), .s_addr_tready(s_addr_tready),
    .s_data_tdata(s_data_tdata), .s_data_tlast(s_data_tlast), .s_data_tvalid(s_data_tvalid),
    .s_data_tready(s_data_tready),
    .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
    .m_sts_tdata(m_sts_tdata), .m_sts_tvalid(m_sts_tvalid), .m_sts_tready(m_sts_tready),
    .m_wr_tdata(m_wr_tdata), .m_wr_tkeep(m_wr_tkeep), .m_wr_tlast(m_wr_tlast),
    .m_wr_tvalid(m_wr_tvalid), .m_wr_tready(m_wr_tready),
    .m_cmpl_tdata(m_cmpl_tdata), .m_cmpl_tvalid(m_cmpl_tvalid), .m_cmpl_tready(m_cmpl_tready),
    .frag_err_o(frag_err_o)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic [11:0] addr_q[$];
  beat_t       data_q[$];
  logic [7:0]  sts_q[$];
  logic [71:0] exp_cmd_q[$];
  beat_t       exp_wr_q[$];
  logic [63:0] exp_cmpl_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cmd_hs = 0, wr_hs = 0, cmpl_hs = 0;
  bit stall_en = 0;
  bit flush = 0;
  bit exp_frag_err = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [71:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected beat %h, expected none", name, act);
  endtask

  function automatic logic [71:0] cmd_word(input logic [11:0] up);
    return {8'h00, 1'b0, up, 19'h03E80, 1'b0, 1'b1, 6'b000000, 1'b1, 23'd64};
  endfunction

  function automatic logic [31:0] model_err(input int n, input logic [7:0] sts);
    logic [31:0] e;
    e = 32'h0;
    e[0] = sts[6];
    e[1] = sts[5];
    e[2] = sts[4];
    e[3] = ~sts[7];
    e[4] = (n < 8);
    e[5] = (n > 8);
    return e;
  endfunction

  // Queue one event: expected responses first, then the source tokens.
  task automatic issue(input logic [11:0] up, input int n, input logic [7:0] sts,
                       input bit with_sts, input logic [71:0] ecmd, input logic [31:0] eerr);
    logic [63:0] din[$];
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == n - 1);
      din.push_back(b.d);
      data_q.push_back(b);
    end
    for (int i = 0; i < 8; i++) begin
      b.d = (i < n) ? din[i] : 64'h0;
      b.l = (i == 7);
      exp_wr_q.push_back(b);
    end
    exp_cmd_q.push_back(ecmd);
    exp_cmpl_q.push_back({20'h00000, up, eerr});
    if (eerr != 32'h0) exp_frag_err = 1;
    if (with_sts) sts_q.push_back(sts);
    addr_q.push_back(up);
    $display("issue: addr=%h beats=%0d sts=%h exp_err=%h", up, n, sts, eerr);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int cyc;
    cyc = 0;
    while ((addr_q.size() + data_q.size() + sts_q.size() + exp_cmd_q.size() +
            exp_wr_q.size() + exp_cmpl_q.size()) != 0 && cyc < limit) begin
      @(posedge memclk);
      cyc++;
    end
    if (cyc >= limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, required drained queues", name, cyc);
    end
    repeat (2) @(posedge memclk);
    #1;
  endtask

  // Sinks: DataMover command/write ports and completion consumer.
  initial begin
    m_cmd_tready = 0; m_wr_tready = 0; m_cmpl_tready = 0;
    forever begin
      @(posedge memclk); #1;
      m_cmd_tready  = stall_en ? ($urandom_range(3) != 0) : 1'b1;
      m_wr_tready   = stall_en ? ($urandom_range(3) != 0) : 1'b1;
      m_cmpl_tready = stall_en ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  initial begin
    s_addr_tvalid = 0; s_addr_tdata = '0;
    forever begin
      @(posedge memclk); #1;
      if (addr_q.size() == 0 || (stall_en && $urandom_range(3) == 0)) begin
        s_addr_tvalid = 0;
      end else begin
        s_addr_tdata  = addr_q.pop_front();
        s_addr_tvalid = 1;
        do @(negedge memclk); while (!s_addr_tready && !flush);
      end
    end
  end

  initial begin
    beat_t b;
    s_data_tvalid = 0; s_data_tdata = '0; s_data_tlast = 0;
    forever begin
      @(posedge memclk); #1;
      if (data_q.size() == 0 || (stall_en && $urandom_range(3) == 0)) begin
        s_data_tvalid = 0;
      end else begin
        b = data_q.pop_front();
        s_data_tdata  = b.d;
        s_data_tlast  = b.l;
        s_data_tvalid = 1;
        do @(negedge memclk); while (!s_data_tready && !flush);
      end
    end
  end

  initial begin
    m_sts_tvalid = 0; m_sts_tdata = '0;
    forever begin
      @(posedge memclk); #1;
      if (sts_q.size() == 0 || (stall_en && $urandom_range(3) == 0)) begin
        m_sts_tvalid = 0;
      end else begin
        m_sts_tdata  = sts_q.pop_front();
        m_sts_tvalid = 1;
        do @(negedge memclk); while (!m_sts_tready && !flush);
      end
    end
  end

  // Monitor: compare every handshake against the scoreboard and check hold rules.
  bit          cmd_pend = 0, cmpl_pend = 0;
  logic [71:0] cmd_prev;
  logic [63:0] cmpl_prev;
  always @(negedge memclk) begin
    if (!memresetn) begin
      cmd_pend  = 0;
      cmpl_pend = 0;
    end else begin
      if (cmd_pend) begin
        check("cmd_hold_valid", m_cmd_tvalid, 1'b1);
        check("cmd_hold_data", m_cmd_tdata, cmd_prev);
      end
      if (cmpl_pend) begin
        check("cmpl_hold_valid", m_cmpl_tvalid, 1'b1);
        check("cmpl_hold_data", m_cmpl_tdata, cmpl_prev);
      end
      cmd_pend  = m_cmd_tvalid && !m_cmd_tready;
      cmd_prev  = m_cmd_tdata;
      cmpl_pend = m_cmpl_tvalid && !m_cmpl_tready;
      cmpl_prev = m_cmpl_tdata;

      if (m_cmd_tvalid && m_cmd_tready) begin
        cmd_hs++;
        $display("cmd: %h", m_cmd_tdata);
        if (exp_cmd_q.size() == 0) unexpected("cmd", m_cmd_tdata);
        else check("cmd", m_cmd_tdata, exp_cmd_q.pop_front());
      end
      if (m_wr_tvalid && m_wr_tready) begin
        wr_hs++;
        if (exp_wr_q.size() == 0) unexpected("wr", {7'h0, m_wr_tdata, m_wr_tlast});
        else check("wr", {7'h0, m_wr_tdata, m_wr_tlast}, {7'h0, exp_wr_q.pop_front()});
        check("wr_tkeep", m_wr_tkeep, 8'hFF);
      end
      if (m_cmpl_tvalid && m_cmpl_tready) begin
        cmpl_hs++;
        $display("cmpl: %h", m_cmpl_tdata);
        if (exp_cmpl_q.size() == 0) unexpected("cmpl", m_cmpl_tdata);
        else check("cmpl", m_cmpl_tdata, exp_cmpl_q.pop_front());
      end
    end
  end

  initial begin
    repeat (50000) @(posedge memclk);
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation reached 50000 cycles, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int c0, k0, w0, cyc;
    logic [11:0] up;
    logic [7:0]  sts;
    logic [7:0]  sts_tab[7];
    int n;
    sts_tab = '{8'h80, 8'h80, 8'h80, 8'h40, 8'h20, 8'h10, 8'h90};

    repeat (3) @(posedge memclk);
    #1;
    check("rst_addr_tready", s_addr_tready, 1'b1);
    check("rst_cmd_tvalid", m_cmd_tvalid, 1'b0);
    check("rst_wr_tvalid", m_wr_tvalid, 1'b0);
    check("rst_cmpl_tvalid", m_cmpl_tvalid, 1'b0);
    check("rst_data_tready", s_data_tready, 1'b0);
    check("rst_sts_tready", m_sts_tready, 1'b0);
    check("rst_frag_err", frag_err_o, 1'b0);
    @(negedge memclk);
    memresetn = 1;

    issue(12'hABC, 8, 8'h80, 1, 72'h00_55E03E80_40800040, 32'h00000000);
    wait_drain("clean", 2000);
    check("frag_err_clean", frag_err_o, 1'b0);

    issue(12'h123, 5, 8'h80, 1, 72'h00_09183E80_40800040, 32'h00000010);
    wait_drain("short", 2000);
    check("frag_err_short", frag_err_o, 1'b1);

    issue(12'hFFF, 11, 8'h80, 1, 72'h00_7FF83E80_40800040, 32'h00000020);
    wait_drain("long", 2000);
    check("frag_err_long", frag_err_o, 1'b1);

    issue(12'h001, 8, 8'h40, 1, 72'h00_00083E80_40800040, 32'h00000009);
    wait_drain("slverr", 2000);

    stall_en = 1;
    c0 = cmd_hs;
    k0 = cmpl_hs;
    for (int e = 0; e < 100; e++) begin
      up  = 12'($urandom_range(4095));
      n   = ($urandom_range(3) == 0) ? $urandom_range(5, 11) : 8;
      sts = sts_tab[$urandom_range(6)];
      issue(up, n, sts, 1, cmd_word(up), model_err(n, sts));
    end
    wait_drain("random", 20000);
    check("random_cmd_count", 72'(cmd_hs - c0), 72'd100);
    check("random_cmpl_count", 72'(cmpl_hs - k0), 72'd100);
    check("frag_err_random", frag_err_o, exp_frag_err);
    stall_en = 0;
    repeat (3) @(posedge memclk);

    // Abandon a fragment by reset while beat 3 is in flight.
    w0 = wr_hs;
    k0 = cmpl_hs;
    issue(12'h2A5, 8, 8'h80, 0, cmd_word(12'h2A5), 32'h0);
    cyc = 0;
    while (wr_hs < w0 + 3 && cyc < 1000) begin
      @(negedge memclk); #1;
      cyc++;
    end
    check("reset_reach_beat3", 72'(wr_hs - w0), 72'd3);
    @(posedge memclk); #2;
    flush = 1;
    memresetn = 0;
    data_q.delete();
    exp_wr_q.delete();
    exp_cmpl_q.delete();
    exp_frag_err = 0;
    #1;
    check("midrst_cmd_tvalid", m_cmd_tvalid, 1'b0);
    check("midrst_wr_tvalid", m_wr_tvalid, 1'b0);
    check("midrst_cmpl_tvalid", m_cmpl_tvalid, 1'b0);
    check("midrst_data_tready", s_data_tready, 1'b0);
    check("midrst_addr_tready", s_addr_tready, 1'b1);
    check("midrst_frag_err", frag_err_o, 1'b0);
    repeat (3) @(posedge memclk);
    @(negedge memclk);
    memresetn = 1;
    flush = 0;

    issue(12'h3C3, 8, 8'h80, 1, 72'h00_1E183E80_40800040, 32'h00000000);
    wait_drain("post_reset", 2000);
    check("post_reset_cmpl_count", 72'(cmpl_hs - k0), 72'd1);
    check("frag_err_post_reset", frag_err_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
